// File: rtl/xbar_nxm_rr.sv
// xbar_nxm_rr: NM-master x NS-slave single-beat req/ack crossbar.
// Each slave has a registered round-robin arbiter that holds the grant until
// the slave acks. Out-of-range addresses get a decode-error response, and a
// stalled slave gets a timeout error response.
module xbar_nxm_rr #(
    parameter int NM     = 4,
    parameter int NS     = 4,
    parameter int CMD_W  = 1,
    parameter int AW     = 12,
    parameter int DW     = 32,
    parameter int SW     = 4,
    parameter int TO_CYC = 255
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [NM-1:0]     iMstReq,
    input  logic [NM*CMD_W-1:0] iMstCmd,
    input  logic [NM*AW-1:0]  iMstAddr,
    input  logic [NM*SW-1:0]  iMstSel,
    input  logic [NM*DW-1:0]  iMstWData,
    output logic [NM-1:0]     oMstAck,
    output logic [NM-1:0]     oMstErr,
    output logic [NM*DW-1:0]  oMstRData,
    output logic [NS-1:0]     oSlvReq,
    output logic [NS*CMD_W-1:0] oSlvCmd,
    output logic [NS*AW-1:0]  oSlvAddr,
    output logic [NS*SW-1:0]  oSlvSel,
    output logic [NS*DW-1:0]  oSlvWData,
    input  logic [NS-1:0]     iSlvAck,
    input  logic [NS*DW-1:0]  iSlvRData,
    output logic [NS*4-1:0]   oSlvGnt
);
    localparam int SIW = (NS > 1) ? $clog2(NS) : 1;
    localparam int MIW = (NM > 1) ? $clog2(NM) : 1;
    // Last count value before the timeout fires (unused when TO_CYC == 0).
    localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

    logic [NS-1:0]  busy_q, busy_d;
    logic [MIW-1:0] gnt_q [NS];
    logic [MIW-1:0] gnt_d [NS];
    logic [MIW-1:0] ptr_q [NS];
    logic [MIW-1:0] ptr_d [NS];
    logic [15:0]    cnt_q [NS];
    logic [15:0]    cnt_d [NS];
    logic [NM-1:0]  derr_q, derr_d;

    logic [SIW-1:0] tgt [NM];
    logic [NM-1:0]  bad_tgt;
    logic [NS-1:0]  to_hit;
    logic [NS-1:0]  done;
    logic [NM-1:0]  ack_c, err_c;
    logic [DW-1:0]  rdata_c [NM];

    // Pointer successor, wrapping modulo NM (NM need not be a power of two).
    function automatic logic [MIW-1:0] rr_next(input logic [MIW-1:0] g);
        int n;
        n = int'(g) + 1;
        if (n >= NM) n = 0;
        return MIW'(n);
    endfunction

    // Address decode and the one-shot decode-error flag per master.
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            tgt[m]     = iMstAddr[m*AW + AW - SIW +: SIW];
            bad_tgt[m] = (int'(tgt[m]) >= NS);
            derr_d[m]  = iMstReq[m] & bad_tgt[m] & ~derr_q[m];
        end
    end

    // Completion per slave (slave ack beats timeout) and per-master response.
    always_comb begin
        ack_c = '0;
        err_c = '0;
        for (int m = 0; m < NM; m++) rdata_c[m] = '0;
        for (int s = 0; s < NS; s++) begin
            to_hit[s] = (TO_CYC > 0) && busy_q[s] && !iSlvAck[s] && (cnt_q[s] == TO_LAST);
            done[s]   = busy_q[s] && (iSlvAck[s] || to_hit[s]);
            if (done[s]) begin
                ack_c[gnt_q[s]]   = 1'b1;
                err_c[gnt_q[s]]   = to_hit[s];
                rdata_c[gnt_q[s]] = to_hit[s] ? '0 : iSlvRData[s*DW +: DW];
            end
        end
        for (int m = 0; m < NM; m++) begin
            if (derr_q[m]) begin
                ack_c[m]   = 1'b1;
                err_c[m]   = 1'b1;
                rdata_c[m] = '0;
            end
        end
    end

    // Per-slave arbiter: IDLE picks round-robin, BUSY waits for ack or timeout.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        for (int s = 0; s < NS; s++) begin
            busy_d[s] = busy_q[s];
            gnt_d[s]  = gnt_q[s];
            ptr_d[s]  = ptr_q[s];
            cnt_d[s]  = cnt_q[s];
            if (busy_q[s]) begin
                if (done[s]) begin
                    busy_d[s] = 1'b0;
                    ptr_d[s]  = rr_next(gnt_q[s]);
                end else begin
                    cnt_d[s] = cnt_q[s] + 16'd1;
                end
            end else begin
                found = 1'b0;
                for (int i = 0; i < NM; i++) begin
                    idx = int'(ptr_q[s]) + i;
                    if (idx >= NM) idx = idx - NM;
                    if (!found && iMstReq[idx] && !bad_tgt[idx] &&
                        (int'(tgt[idx]) == s) && !ack_c[idx]) begin
                        found    = 1'b1;
                        gnt_d[s] = MIW'(idx);
                    end
                end
                if (found) begin
                    busy_d[s] = 1'b1;
                    cnt_d[s]  = '0;
                end
            end
        end
    end

    // Output muxing: granted master's fields per slave, responses per master.
    always_comb begin
        oSlvReq   = busy_q;
        oSlvCmd   = '0;
        oSlvAddr  = '0;
        oSlvSel   = '0;
        oSlvWData = '0;
        oSlvGnt   = '0;
        for (int s = 0; s < NS; s++) begin
            if (busy_q[s]) begin
                oSlvGnt[s*4 +: 4]         = 4'(gnt_q[s]);
                oSlvCmd[s*CMD_W +: CMD_W] = iMstCmd[int'(gnt_q[s])*CMD_W +: CMD_W];
                oSlvAddr[s*AW +: AW]      = iMstAddr[int'(gnt_q[s])*AW +: AW];
                oSlvSel[s*SW +: SW]       = iMstSel[int'(gnt_q[s])*SW +: SW];
                oSlvWData[s*DW +: DW]     = iMstWData[int'(gnt_q[s])*DW +: DW];
            end
        end
        // A reset cycle aborts any in-flight transfer without a response.
        oMstAck   = iRst ? '0 : ack_c;
        oMstErr   = iRst ? '0 : err_c;
        oMstRData = '0;
        for (int m = 0; m < NM; m++) begin
            if (!iRst) oMstRData[m*DW +: DW] = rdata_c[m];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            busy_q <= '0;
            derr_q <= '0;
            for (int s = 0; s < NS; s++) begin
                gnt_q[s] <= '0;
                ptr_q[s] <= '0;
                cnt_q[s] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            derr_q <= derr_d;
            for (int s = 0; s < NS; s++) begin
                gnt_q[s] <= gnt_d[s];
                ptr_q[s] <= ptr_d[s];
                cnt_q[s] <= cnt_d[s];
            end
        end
    end

endmodule

// File: tb/tb_xbar_nxm_rr.sv
// Testbench for xbar_nxm_rr: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_xbar_nxm_rr;
    localparam int NM = 4, NS = 4, NSB = 3, CMD_W = 1, AW = 12, DW = 32, SW = 4, TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic [NM-1:0]       mreq, mreq_b;
    logic [NM*CMD_W-1:0] mcmd;
    logic [NM*AW-1:0]    maddr;
    logic [NM*SW-1:0]    msel;
    logic [NM*DW-1:0]    mwdata;
    logic [NM-1:0]       mack, merr;
    logic [NM*DW-1:0]    mrdata;
    logic [NS-1:0]       sreq;
    logic [NS*CMD_W-1:0] scmd;
    logic [NS*AW-1:0]    saddr;
    logic [NS*SW-1:0]    ssel;
    logic [NS*DW-1:0]    swdata;
    logic [NS-1:0]       sack;
    logic [NS*DW-1:0]    srdata;
    logic [NS*4-1:0]     sgnt;
    logic [NM-1:0]        mack_b, merr_b;
    logic [NM*DW-1:0]     mrdata_b;
    logic [NSB-1:0]       sreq_b;
    logic [NSB*CMD_W-1:0] scmd_b;
    logic [NSB*AW-1:0]    saddr_b;
    logic [NSB*SW-1:0]    ssel_b;
    logic [NSB*DW-1:0]    swdata_b;
    logic [NSB-1:0]       sack_b;
    logic [NSB*DW-1:0]    srdata_b;
    logic [NSB*4-1:0]     sgnt_b;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xbar_nxm_rr #(.NM(NM), .NS(NS), .CMD_W(CMD_W), .AW(AW), .DW(DW), .SW(SW), .TO_CYC(TO)) dut (
        .iClk(clk), .iRst(rst), .iMstReq(mreq), .iMstCmd(mcmd), .iMstAddr(maddr),
        .iMstSel(msel), .iMstWData(mwdata), .oMstAck(mack), .oMstErr(merr),
        .oMstRData(mrdata), .oSlvReq(sreq), .oSlvCmd(scmd), .oSlvAddr(saddr),
        .oSlvSel(ssel), .oSlvWData(swdata), .iSlvAck(sack), .iSlvRData(srdata),
        .oSlvGnt(sgnt));

    xbar_nxm_rr #(.NM(NM), .NS(NSB), .CMD_W(CMD_W), .AW(AW), .DW(DW), .SW(SW), .TO_CYC(0)) dut_b (
        .iClk(clk), .iRst(rst), .iMstReq(mreq_b), .iMstCmd(mcmd), .iMstAddr(maddr),
        .iMstSel(msel), .iMstWData(mwdata), .oMstAck(mack_b), .oMstErr(merr_b),
        .oMstRData(mrdata_b), .oSlvReq(sreq_b), .oSlvCmd(scmd_b), .oSlvAddr(saddr_b),
        .oSlvSel(ssel_b), .oSlvWData(swdata_b), .iSlvAck(sack_b), .iSlvRData(srdata_b),
        .oSlvGnt(sgnt_b));

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mst(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] sel, input logic cmd);
        maddr[m*AW +: AW]  = a;
        mwdata[m*DW +: DW] = d;
        msel[m*SW +: SW]   = sel;
        mcmd[m]            = cmd;
    endtask

    task automatic test_reset();
        rst = 1'b1; mreq = '1; mreq_b = '1; sack = '1; sack_b = '1;
        maddr = {12'hC00, 12'h800, 12'h400, 12'h000};
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_run++; if (mack !== 4'b0 || merr !== 4'b0 || mrdata !== '0) begin n_fail++; $display("FAIL reset_mst: ack %b err %b rdata %h want 0", mack, merr, mrdata); end
        n_run++; if (sreq !== 4'b0 || sgnt !== 16'h0 || saddr !== '0 || swdata !== '0) begin n_fail++; $display("FAIL reset_slv: req %b gnt %h addr %h want 0", sreq, sgnt, saddr); end
        n_run++; if (mack_b !== 4'b0 || sreq_b !== 3'b0) begin n_fail++; $display("FAIL reset_b: ack %b req %b want 0", mack_b, sreq_b); end
        next_cycle();
        rst = 1'b0; mreq = '0; mreq_b = '0; sack_b = '0;
        @(negedge clk);
        n_run++; if (mack !== 4'b0 || sreq !== 4'b0) begin n_fail++; $display("FAIL idle_ack_ignored: ack %b req %b want 0", mack, sreq); end
        next_cycle();
        sack = '0;
    endtask

    task automatic test_single_access();
        set_mst(1, 12'h8A0, 32'h1234_5678, 4'hF, 1'b1);
        mreq[1] = 1'b1;
        @(negedge clk);
        n_run++; if (sreq !== 4'b0) begin n_fail++; $display("FAIL single_t0_req: got %b want 0000", sreq); end
        next_cycle(); @(negedge clk);
        n_run++; if (sreq !== 4'b0100) begin n_fail++; $display("FAIL single_req: got %b want 0100", sreq); end
        n_run++; if (sgnt !== 16'h0100) begin n_fail++; $display("FAIL single_gnt: got %h want 0100", sgnt); end
        n_run++; if (saddr !== {12'h0, 12'h8A0, 24'h0}) begin n_fail++; $display("FAIL single_addr: got %h", saddr); end
        n_run++; if (swdata !== {32'h0, 32'h1234_5678, 64'h0} || ssel !== 16'h0F00 || scmd !== 4'b0100) begin n_fail++; $display("FAIL single_fields: wd %h sel %h cmd %b", swdata, ssel, scmd); end
        next_cycle(); @(negedge clk);
        n_run++; if (sreq !== 4'b0100 || mack !== 4'b0) begin n_fail++; $display("FAIL single_wait: req %b ack %b want 0100/0000", sreq, mack); end
        next_cycle();
        sack[2] = 1'b1; srdata[2*DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        n_run++; if (mack !== 4'b0010 || merr !== 4'b0) begin n_fail++; $display("FAIL single_ack: ack %b err %b want 0010/0000", mack, merr); end
        n_run++; if (mrdata !== {64'h0, 32'hDEAD_BEEF, 32'h0}) begin n_fail++; $display("FAIL single_rdata: got %h", mrdata); end
        next_cycle();
        sack = '0; srdata = '0; mreq = '0;
        @(negedge clk);
        n_run++; if (sreq !== 4'b0 || sgnt !== 16'h0 || mack !== 4'b0) begin n_fail++; $display("FAIL single_end: req %b gnt %h ack %b", sreq, sgnt, mack); end
    endtask

    task automatic test_round_robin();
        int order [5];
        int bc;
        logic       e_req;
        logic [3:0] e_gnt, e_ack;
        order = '{0, 1, 2, 3, 0};
        bc = 0;
        next_cycle();
        for (int m = 0; m < NM; m++) set_mst(m, 12'(16 * m + 1), 32'hA000_0000 + 32'(m), 4'h3, 1'b0);
        mreq = '1;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) next_cycle();
            sack[0] = (bc == 1);
            @(negedge clk);
            bc = sreq[0] ? bc + 1 : 0;
            e_req = (k % 3 != 0);
            e_gnt = e_req ? 4'(order[(k - 1) / 3]) : 4'd0;
            e_ack = (k % 3 == 2) ? 4'(1 << order[k / 3]) : 4'd0;
            n_run++; if (sreq !== {3'b0, e_req} || sgnt[3:0] !== e_gnt) begin n_fail++; $display("FAIL rr_grant k=%0d: req %b gnt %0d want %b/%0d", k, sreq, sgnt[3:0], e_req, e_gnt); end
            n_run++; if (mack !== e_ack || merr !== 4'b0) begin n_fail++; $display("FAIL rr_ack k=%0d: ack %b err %b want %b/0000", k, mack, merr, e_ack); end
        end
        next_cycle();
        mreq = '0; sack = '0;
        @(negedge clk);
        n_run++; if (sreq !== 4'b0) begin n_fail++; $display("FAIL rr_end: req %b want 0000", sreq); end
    endtask

    task automatic test_parallel();
        next_cycle();
        set_mst(0, 12'hC00, 32'h0000_AAAA, 4'h1, 1'b1);
        set_mst(3, 12'h055, 32'h0000_BBBB, 4'h8, 1'b0);
        mreq = 4'b1001;
        @(negedge clk);
        n_run++; if (sreq !== 4'b0) begin n_fail++; $display("FAIL par_t0: req %b want 0000", sreq); end
        next_cycle();
        sack[0] = 1'b1; srdata[0 +: DW] = 32'h1111_2222;
        @(negedge clk);
        n_run++; if (sreq !== 4'b1001 || sgnt !== 16'h0003) begin n_fail++; $display("FAIL par_req: req %b gnt %h want 1001/0003", sreq, sgnt); end
        n_run++; if (saddr !== {12'hC00, 24'h0, 12'h055}) begin n_fail++; $display("FAIL par_addr: got %h", saddr); end
        n_run++; if (mack !== 4'b1000 || merr !== 4'b0 || mrdata !== {32'h1111_2222, 96'h0}) begin n_fail++; $display("FAIL par_ack_s0: ack %b err %b rdata %h", mack, merr, mrdata); end
        next_cycle();
        sack = '0; mreq[3] = 1'b0;
        @(negedge clk);
        n_run++; if (sreq !== 4'b1000 || mack !== 4'b0) begin n_fail++; $display("FAIL par_mid: req %b ack %b want 1000/0000", sreq, mack); end
        next_cycle();
        sack[3] = 1'b1; srdata[3*DW +: DW] = 32'h3333_4444;
        @(negedge clk);
        n_run++; if (mack !== 4'b0001 || mrdata !== {96'h0, 32'h3333_4444}) begin n_fail++; $display("FAIL par_ack_s3: ack %b rdata %h", mack, mrdata); end
        next_cycle();
        sack = '0; srdata = '0; mreq = '0;
        @(negedge clk);
        n_run++; if (sreq !== 4'b0) begin n_fail++; $display("FAIL par_end: req %b want 0000", sreq); end
    endtask

    task automatic test_decode_err();
        next_cycle();
        set_mst(2, 12'hC40, 32'h0000_0005, 4'hF, 1'b1);
        mreq_b = 4'b0100;
        @(negedge clk);
        n_run++; if (mack_b !== 4'b0) begin n_fail++; $display("FAIL derr_t0: ack %b want 0000", mack_b); end
        next_cycle(); @(negedge clk);
        n_run++; if (mack_b !== 4'b0100 || merr_b !== 4'b0100 || mrdata_b !== '0) begin n_fail++; $display("FAIL derr_ack: ack %b err %b rdata %h", mack_b, merr_b, mrdata_b); end
        n_run++; if (sreq_b !== 3'b0) begin n_fail++; $display("FAIL derr_noslv: req %b want 000", sreq_b); end
        next_cycle(); @(negedge clk);
        n_run++; if (mack_b !== 4'b0) begin n_fail++; $display("FAIL derr_once: ack %b want 0000", mack_b); end
        next_cycle(); @(negedge clk);
        n_run++; if (mack_b !== 4'b0100 || merr_b !== 4'b0100) begin n_fail++; $display("FAIL derr_second: ack %b err %b want 0100", mack_b, merr_b); end
        next_cycle();
        mreq_b = '0;
        @(negedge clk);
        n_run++; if (mack_b !== 4'b0 || sreq_b !== 3'b0) begin n_fail++; $display("FAIL derr_end: ack %b req %b", mack_b, sreq_b); end
    endtask

    task automatic test_no_timeout();
        next_cycle();
        set_mst(0, 12'h400, 32'h0000_0077, 4'h2, 1'b0);
        mreq_b = 4'b0001;
        for (int b = 1; b <= 20; b++) begin
            next_cycle(); @(negedge clk);
            n_run++; if (mack_b !== 4'b0 || sreq_b !== 3'b010) begin n_fail++; $display("FAIL noto_wait b=%0d: ack %b req %b want 0000/010", b, mack_b, sreq_b); end
        end
        next_cycle();
        sack_b[1] = 1'b1; srdata_b[DW +: DW] = 32'h0BAD_F00D;
        @(negedge clk);
        n_run++; if (mack_b !== 4'b0001 || merr_b !== 4'b0 || mrdata_b[DW-1:0] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL noto_ack: ack %b err %b rdata %h", mack_b, merr_b, mrdata_b); end
        next_cycle();
        sack_b = '0; srdata_b = '0; mreq_b = '0;
    endtask

    task automatic test_timeout();
        next_cycle();
        set_mst(2, 12'h400, 32'h0000_0099, 4'h4, 1'b1);
        mreq = 4'b0100;
        @(negedge clk);
        for (int b = 1; b <= 8; b++) begin
            next_cycle(); @(negedge clk);
            if (b < 8) begin
                n_run++; if (mack !== 4'b0 || sreq !== 4'b0010) begin n_fail++; $display("FAIL to_wait b=%0d: ack %b req %b", b, mack, sreq); end
            end else begin
                n_run++; if (mack !== 4'b0100 || merr !== 4'b0100 || mrdata !== '0) begin n_fail++; $display("FAIL to_err: ack %b err %b rdata %h want 0100/0100/0", mack, merr, mrdata); end
            end
        end
        next_cycle();
        mreq = '0; sack[1] = 1'b1; srdata[DW +: DW] = 32'hFFFF_0000;
        @(negedge clk);
        n_run++; if (mack !== 4'b0 || sreq !== 4'b0) begin n_fail++; $display("FAIL to_late_ack: ack %b req %b want 0", mack, sreq); end
        next_cycle();
        sack = '0; mreq = 4'b0100;
        @(negedge clk);
        for (int b = 1; b <= 8; b++) begin
            next_cycle();
            if (b == 8) begin sack[1] = 1'b1; srdata[DW +: DW] = 32'hCAFE_F00D; end
            @(negedge clk);
            if (b < 8) begin
                n_run++; if (mack !== 4'b0) begin n_fail++; $display("FAIL to2_wait b=%0d: ack %b", b, mack); end
            end else begin
                n_run++; if (mack !== 4'b0100 || merr !== 4'b0 || mrdata !== {32'h0, 32'hCAFE_F00D, 64'h0}) begin n_fail++; $display("FAIL to_ack_wins: ack %b err %b rdata %h", mack, merr, mrdata); end
            end
        end
        next_cycle();
        sack = '0; srdata = '0; mreq = '0;
        @(negedge clk);
        n_run++; if (sreq !== 4'b0) begin n_fail++; $display("FAIL to_end: req %b", sreq); end
    endtask

    task automatic test_reset_busy();
        next_cycle();
        set_mst(1, 12'h480, 32'h0000_0011, 4'h1, 1'b0);
        mreq = 4'b0010;
        next_cycle(); @(negedge clk);
        n_run++; if (sreq !== 4'b0010 || sgnt !== 16'h0010) begin n_fail++; $display("FAIL rb_busy: req %b gnt %h", sreq, sgnt); end
        next_cycle();
        rst = 1'b1; sack[1] = 1'b1; srdata[DW +: DW] = 32'h5555_5555;
        @(negedge clk);
        n_run++; if (mack !== 4'b0 || merr !== 4'b0) begin n_fail++; $display("FAIL rb_abort: ack %b err %b want 0", mack, merr); end
        next_cycle();
        rst = 1'b0; sack = '0; srdata = '0; mreq = '0;
        @(negedge clk);
        n_run++; if (sreq !== 4'b0 || sgnt !== 16'h0 || mack !== 4'b0 || saddr !== '0) begin n_fail++; $display("FAIL rb_after: req %b gnt %h ack %b", sreq, sgnt, mack); end
        next_cycle();
        set_mst(0, 12'h410, 32'h0000_0022, 4'h2, 1'b0);
        set_mst(3, 12'h4F0, 32'h0000_0033, 4'h3, 1'b0);
        mreq = 4'b1001;
        next_cycle(); @(negedge clk);
        n_run++; if (sreq !== 4'b0010 || sgnt !== 16'h0000 || saddr !== {24'h0, 12'h410, 12'h0}) begin n_fail++; $display("FAIL rb_ptr0: req %b gnt %h addr %h", sreq, sgnt, saddr); end
        next_cycle();
        sack[1] = 1'b1;
        @(negedge clk);
        n_run++; if (mack !== 4'b0001) begin n_fail++; $display("FAIL rb_ack_m0: ack %b want 0001", mack); end
        next_cycle();
        sack = '0; mreq[0] = 1'b0;
        next_cycle();
        sack[1] = 1'b1;
        @(negedge clk);
        n_run++; if (mack !== 4'b1000 || sgnt !== 16'h0030) begin n_fail++; $display("FAIL rb_ack_m3: ack %b gnt %h", mack, sgnt); end
        next_cycle();
        sack = '0; mreq = '0;
    endtask

    task automatic test_random();
        int  owner [NS];
        int  rr [NS];
        int  wcnt [NS];
        bit  pend [NM];
        int  g;
        logic [NM-1:0]       e_ack, e_err;
        logic [NM*DW-1:0]    e_rd;
        logic [NS-1:0]       e_req;
        logic [NS*4-1:0]     e_gnt;
        logic [NS*AW-1:0]    e_addr;
        logic [NS*DW-1:0]    e_wd;
        logic [NS*SW-1:0]    e_sel;
        logic [NS*CMD_W-1:0] e_cmd;
        next_cycle();
        rst = 1'b1; mreq = '0; sack = '0;
        next_cycle();
        rst = 1'b0;
        for (int s = 0; s < NS; s++) begin owner[s] = -1; rr[s] = 0; wcnt[s] = 0; end
        for (int m = 0; m < NM; m++) pend[m] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) next_cycle();
            for (int m = 0; m < NM; m++) begin
                if (!pend[m]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        pend[m] = 1'b1;
                        set_mst(m, AW'($urandom), $urandom, SW'($urandom), 1'($urandom));
                        mreq[m] = 1'b1;
                    end else begin
                        mreq[m] = 1'b0;
                    end
                end
            end
            for (int s = 0; s < NS; s++) begin
                sack[s] = ($urandom_range(0, 3) == 0);
                srdata[s*DW +: DW] = $urandom;
            end
            @(negedge clk);
            e_ack = '0; e_err = '0; e_rd = '0; e_req = '0; e_gnt = '0;
            e_addr = '0; e_wd = '0; e_sel = '0; e_cmd = '0;
            for (int s = 0; s < NS; s++) begin
                if (owner[s] >= 0) begin
                    g = owner[s];
                    e_req[s] = 1'b1;
                    e_gnt[s*4 +: 4]   = 4'(g);
                    e_addr[s*AW +: AW] = maddr[g*AW +: AW];
                    e_wd[s*DW +: DW]   = mwdata[g*DW +: DW];
                    e_sel[s*SW +: SW]  = msel[g*SW +: SW];
                    e_cmd[s]           = mcmd[g];
                    if (sack[s]) begin
                        e_ack[g] = 1'b1;
                        e_rd[g*DW +: DW] = srdata[s*DW +: DW];
                    end else if (wcnt[s] == TO - 1) begin
                        e_ack[g] = 1'b1;
                        e_err[g] = 1'b1;
                    end
                end
            end
            n_run++; if (mack !== e_ack || merr !== e_err) begin n_fail++; $display("FAIL rnd_ack c=%0d: ack %b err %b want %b/%b", c, mack, merr, e_ack, e_err); end
            n_run++; if (mrdata !== e_rd) begin n_fail++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, mrdata, e_rd); end
            n_run++; if (sreq !== e_req || sgnt !== e_gnt) begin n_fail++; $display("FAIL rnd_grant c=%0d: req %b gnt %h want %b/%h", c, sreq, sgnt, e_req, e_gnt); end
            n_run++; if (saddr !== e_addr || swdata !== e_wd || ssel !== e_sel || scmd !== e_cmd) begin n_fail++; $display("FAIL rnd_fields c=%0d: addr %h want %h", c, saddr, e_addr); end
            for (int s = 0; s < NS; s++) begin
                if (owner[s] >= 0) begin
                    if (e_ack[owner[s]]) begin
                        rr[s] = (owner[s] + 1) % NM;
                        owner[s] = -1;
                    end else begin
                        wcnt[s]++;
                    end
                end else begin
                    for (int i = 0; i < NM; i++) begin
                        int m;
                        m = (rr[s] + i) % NM;
                        if (owner[s] < 0 && pend[m] && int'(maddr[m*AW + AW - 2 +: 2]) == s && !e_ack[m]) begin
                            owner[s] = m;
                            wcnt[s] = 0;
                        end
                    end
                end
            end
            for (int m = 0; m < NM; m++) if (e_ack[m]) pend[m] = 1'b0;
        end
        next_cycle();
        mreq = '0; sack = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mreq = '0; mreq_b = '0; mcmd = '0; maddr = '0; msel = '0; mwdata = '0;
        sack = '0; srdata = '0; sack_b = '0; srdata_b = '0;
        test_reset();
        test_single_access();
        test_round_robin();
        test_parallel();
        test_decode_err();
        test_no_timeout();
        test_timeout();
        test_reset_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/xbar_nxm_rr.md
Name: xbar_nxm_rr

Overview:
- Parametrised NM-master x NS-slave single-beat req/ack crossbar; generalised successor of the fixed 4x4 master_if/slave_if interconnect in the switch xbar.
- Each slave port has a registered round-robin arbiter that holds the grant until the slave acks.
- Adds address-based slave decode, a decode-error response, a per-slave ack timeout with error response, and per-slave grant visibility.
- Sits between the switch port engines (masters) and the shared buffer/table memories (slaves).

Parameters:
- NM, 4, number of master ports (2..16).
- NS, 4, number of slave ports (1..16).
- CMD_W, 1, command width (passed through unchanged).
- AW, 12, address width; the top SIW=max(1,clog2(NS)) bits select the slave.
- DW, 32, data width.
- SW, 4, byte-select width (passed through unchanged).
- TO_CYC, 255, ack timeout in cycles; 0 disables the timeout; legal range 0..65535.

Ports:
- iClk  in  1  clock; all logic on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- iMstReq  in  NM  per-master request; held high until acked.
- iMstCmd  in  NM*CMD_W  flattened; master m occupies [m*CMD_W +: CMD_W].
- iMstAddr  in  NM*AW  flattened.
- iMstSel  in  NM*SW  flattened.
- iMstWData  in  NM*DW  flattened.
- oMstAck  out  NM  one-cycle completion pulse.
- oMstErr  out  NM  valid with oMstAck; 1 = decode error or timeout.
- oMstRData  out  NM*DW  read data, valid with oMstAck.
- oSlvReq  out  NS  slave request.
- oSlvCmd  out  NS*CMD_W  granted master's command.
- oSlvAddr  out  NS*AW  granted master's full address.
- oSlvSel  out  NS*SW  granted master's byte select.
- oSlvWData  out  NS*DW  granted master's write data.
- iSlvAck  in  NS  slave completion pulse.
- iSlvRData  in  NS*DW  slave read data, valid with iSlvAck.
- oSlvGnt  out  NS*4  index of the currently granted master per slave; 0 when idle.

Behaviour:
- Reset: all outputs 0, all arbiters IDLE, round-robin pointers 0, timeout counters 0. Reset asserted mid-transaction aborts it; no ack or error is issued for the aborted transaction.
- Handshake:
  - A master holds Req, Cmd, Addr, Sel and WData stable from assertion through its ack cycle.
  - In the cycle after its ack, a master presents either a new request or Req=0.
  - Changing request fields while Req=1 and not yet acked is illegal; the behaviour is undefined.
- Decode: target = iMstAddr[AW-1 -: SIW].
  - target >= NS: oMstAck=1 and oMstErr=1 with RData=0 in the cycle after the request is first seen. A per-master one-cycle flag prevents a repeat response.
  - No slave is touched on a decode error.
- Per-slave arbiter FSM (IDLE, BUSY):
  - IDLE: candidates are masters with Req=1, target equal to this slave, and not already being acked. Round-robin picks the first candidate at or after the pointer, wrapping modulo NM.
  - At the clock edge the grant is registered and the FSM moves to BUSY. oSlvReq=1 from the next cycle.
  - Minimum latency: request seen in cycle t gives oSlvReq in cycle t+1.
  - BUSY: slave outputs are muxed from the granted master. iSlvAck is forwarded combinationally as oMstAck[g]=1, oMstErr[g]=0, oMstRData[g]=iSlvRData in the same cycle.
  - On the ack edge: FSM returns to IDLE, pointer becomes (g+1) mod NM, oSlvReq drops next cycle. Back-to-back grants therefore leave one IDLE cycle between them.
  - iSlvAck while IDLE is ignored.
- Timeout (TO_CYC>0):
  - A 16-bit counter clears on grant and increments each BUSY cycle without ack.
  - In the cycle where count == TO_CYC-1 with no ack: oMstAck[g]=1, oMstErr[g]=1, RData=0. The FSM goes to IDLE and the pointer advances as for a normal ack.
  - If iSlvAck arrives in the same cycle, the normal ack wins with Err=0.
  - A late slave ack after timeout is ignored because the FSM is IDLE.
- A master has at most one outstanding request; at most one slave or error source acks a master in any cycle.
- Different slaves operate fully in parallel; there is no cross-slave ordering guarantee.
- Slave ports not granted drive all request fields to 0.

Test Plan:
- Single access: NM=NS=4; M1 requests addr 0x8A0 (slave 2) at cycle 5, slave acks at cycle 8 with RData=0xDEADBEEF -> oSlvReq[2] high cycles 6-8, oSlvGnt[2]=1, oMstAck[1]=1 and RData=0xDEADBEEF at cycle 8, Err=0.
- Round-robin fairness: all 4 masters continuously request slave 0, slave acks each request 1 cycle after oSlvReq -> grant order 0,1,2,3,0; no master starves; one idle cycle between grants.
- Parallel paths: M0->S3 and M3->S0 both requested at cycle 2 -> both oSlvReq rise at cycle 3 and complete independently.
- Decode error: NS=3, M2 addr top bits = 3 -> oMstAck[2]=1 and Err=1 exactly one cycle later; oSlvReq stays 0.
- Timeout: TO_CYC=8, slave never acks -> Err ack in the 8th BUSY cycle; an ack arriving in exactly that cycle gives Err=0 instead; a late ack afterwards is ignored.
- Reset in BUSY: iRst high for 1 cycle while slave 1 is BUSY -> all outputs 0 the next cycle, no ack issued, pointer back to 0.
